reaction_timer_n: RTL
=====================

# reaction_timer_n

Parametrised reaction-time game core for the Tiny Tapeout seven-segment board. It arms on a start press, waits a pseudo-random delay, lights a GO LED, then counts elapsed ticks in BCD until stop is pressed. The result is shown on a time-multiplexed N-digit display. It supersedes the fixed two-digit game logic and sits directly behind the `ui_in`/`uo_out` pin mapping of the top-level TT wrapper.

## Interface
- `DIGITS`, 2, number of BCD display digits (1..4).
- `TICK_DIV`, 2_000_000, clk cycles per count unit (≥2).
- `SCAN_DIV`, 4, clk cycles each digit stays selected (≥1).
- `SEED`, 16'hACE1, LFSR reset value (nonzero).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  start button, asynchronous level.
- `stop`  in  1  stop button, asynchronous level.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active high.
- `digit_sel`  out  DIGITS  one-hot digit enable; bit 0 = least-significant digit.
- `led_go`  out  1  high while in RUN.
- `foul`  out  1  high while in FOUL.

## Operation
- `start` and `stop` pass through a 2-flop synchroniser, then a rising-edge detector. The detector's previous-value flop resets to 1, so a button held through reset does not fire.
- The 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle and never reaches zero.
- The tick counter counts 0..TICK_DIV-1. `tick` pulses for 1 cycle at TICK_DIV-1. The counter is cleared on entry to WAIT and on entry to RUN.
- The BCD counter is DIGITS×4 bits. It increments on `tick` in RUN with per-digit carry, and saturates at all-9s.
- States, with 3-bit encoding in the package:
  - IDLE: display blank (seg=0); start edge → WAIT.
  - WAIT: on entry, the delay register is loaded with 5 + LFSR[3:0], i.e. 5..20 ticks. The delay is decremented on `tick`.
    - stop edge → FOUL.
    - delay==0 → RUN, and the BCD count is cleared.
  - RUN: `led_go`=1; count on tick; stop edge → SHOW.
  - SHOW: display the frozen count; start edge → WAIT.
  - FOUL: `foul`=1; every digit shows dash (seg=7'b1000000); start edge → WAIT.
- Simultaneous start and stop edges:
  - In WAIT or RUN, stop wins.
  - In IDLE, SHOW or FOUL, start wins.
- Digit scan:
  - The scan counter counts 0..SCAN_DIV-1.
  - The digit index advances on wrap, 0..DIGITS-1 then back to 0.
  - Scanning runs in every state.
- Segment encoding (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Non-BCD values = 0000000.

## Timing
- Reset values:
  - state=IDLE, seg=0, digit_sel=1, led_go=0, foul=0.
  - All counters = 0.
  - LFSR=SEED.
  - Synchroniser flops = 0; edge-detector previous-value flop = 1.
- Button latency: input rises at cycle n → state changes at the clock edge ending cycle n+3 (2 sync + 1 edge register). Outputs reflect the new state 1 cycle later.
- `seg` and `digit_sel` are registered together. They always refer to the same digit, with no glitch between them.
- Count resolution: the first increment occurs exactly TICK_DIV cycles after RUN entry.
- Saturation: count stays at 10^DIGITS−1 while remaining in RUN.
- Reset mid-round returns to IDLE immediately (asynchronous); any pending edge is discarded.

## Structure
- `reaction_pkg` contains:
  - `state_t` enum (IDLE, WAIT, RUN, SHOW, FOUL).
  - `SEG_BLANK` and `SEG_DASH` constants.
  - Function `bcd_to_seg(logic [3:0]) → logic [6:0]`.
- Sub-module `seg_scan_n` (params DIGITS, SCAN_DIV):
  - Takes the packed BCD value plus a blank flag and a dash flag.
  - Owns the scan counter and the registered `seg`/`digit_sel` outputs.
- The top level holds the FSM, LFSR, tick divider, delay register and BCD counter.

## Test plan
All scenarios use DIGITS=2, TICK_DIV=4, SCAN_DIV=2, SEED=16'hACE1.

- Reset with start held high → stays IDLE; seg=0; digit_sel cycles 01,10 every 2 cycles.
- Start pulse, stop withheld → WAIT lasts (5+LFSR[3:0])×4 cycles (checked against reference model LFSR); then led_go=1.
- In RUN, assert stop after 7 ticks → SHOW. Digit 0 seg=0000111 ('7') and digit 1 seg=0111111 ('0'); led_go=0.
- Stop pressed during WAIT → foul=1; both digits show 1000000. A following start → WAIT, foul=0.
- RUN for 120 ticks → count stops at 99 (both digits 1101111); a later stop → SHOW 99.
- Start and stop rise on the same cycle:
  - In RUN → SHOW.
  - In SHOW → WAIT.
- Asynchronous reset asserted mid-RUN → outputs at reset values within the same cycle.

Source files
------------

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types, display constants and segment decoder for the reaction timer
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        RUN  = 3'd2,
        SHOW = 3'd3,
        FOUL = 3'd4
    } state_t;

    localparam logic [6:0]  SEG_BLANK = 7'b0000000;
    localparam logic [6:0]  SEG_DASH  = 7'b1000000;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_n.sv
// rtl/seg_scan_n.sv - time-multiplexed N-digit seven-segment scanner with registered outputs
module seg_scan_n
    import reaction_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   bcd,
    input  logic                  blank,
    input  logic                  dash,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;

    // seg and digit_sel are both built from the next index so they always change on the same edge.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        sel_d        = '0;
        sel_d[idx_d] = 1'b1;
        if (blank) begin
            seg_d = SEG_BLANK;
        end else if (dash) begin
            seg_d = SEG_DASH;
        end else begin
            seg_d = bcd_to_seg(bcd[4*idx_d +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_BLANK;
            sel_q  <= DIGITS'(1);
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: rtl/reaction_timer_n.sv
// rtl/reaction_timer_n.sv - reaction-time game core: button sync, FSM, LFSR delay, tick divider, BCD count
module reaction_timer_n
    import reaction_pkg::*;
#(
    parameter int          DIGITS   = 2,
    parameter int          TICK_DIV = 2_000_000,
    parameter int          SCAN_DIV = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] digit_sel,
    output logic              led_go,
    output logic              foul
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = DIGITS * 4;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    logic          start_s1_q, start_s1_d, start_s2_q, start_s2_d;
    logic          start_prev_q, start_prev_d, start_edge_q, start_edge_d;
    logic          stop_s1_q, stop_s1_d, stop_s2_q, stop_s2_d;
    logic          stop_prev_q, stop_prev_d, stop_edge_q, stop_edge_d;
    logic [1:0]    vld_q, vld_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [4:0]    delay_q, delay_d;
    logic [BW-1:0] bcd_q, bcd_d, bcd_inc;
    state_t        state_q, state_d;
    logic          led_go_q, led_go_d, foul_q, foul_d;
    logic          tick, all_nines, carry;

    // vld_q marks when the synchronisers hold real samples; until then prev stays 1
    // so a button held through reset never looks like a fresh press.
    always_comb begin
        vld_d        = {vld_q[0], 1'b1};
        start_s1_d   = start;
        start_s2_d   = start_s1_q;
        start_prev_d = vld_q[1] ? start_s2_q : 1'b1;
        start_edge_d = vld_q[1] & start_s2_q & ~start_prev_q;
        stop_s1_d    = stop;
        stop_s2_d    = stop_s1_q;
        stop_prev_d  = vld_q[1] ? stop_s2_q : 1'b1;
        stop_edge_d  = vld_q[1] & stop_s2_q & ~stop_prev_q;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign tick = (tick_cnt_q == TICK_MAX);

    always_comb begin
        all_nines = 1'b1;
        carry     = 1'b1;
        bcd_inc   = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (all_nines) bcd_inc = bcd_q;
    end

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        bcd_d      = bcd_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        case (state_q)
            IDLE, SHOW, FOUL: begin
                if (start_edge_q) begin
                    state_d    = WAIT;
                    delay_d    = 5'd5 + {1'b0, lfsr_q[3:0]};
                    tick_cnt_d = '0;
                end
            end
            WAIT: begin
                if (stop_edge_q) begin
                    state_d = FOUL;
                end else if (tick) begin
                    delay_d = delay_q - 5'd1;
                    if (delay_d == 5'd0) begin
                        state_d    = RUN;
                        bcd_d      = '0;
                        tick_cnt_d = '0;
                    end
                end
            end
            RUN: begin
                if (tick) bcd_d = bcd_inc;
                if (stop_edge_q) state_d = SHOW;
            end
            default: state_d = IDLE;
        endcase
        led_go_d = (state_q == RUN);
        foul_d   = (state_q == FOUL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q        <= 2'b00;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b1;
            start_edge_q <= 1'b0;
            stop_s1_q    <= 1'b0;
            stop_s2_q    <= 1'b0;
            stop_prev_q  <= 1'b1;
            stop_edge_q  <= 1'b0;
            lfsr_q       <= SEED;
            tick_cnt_q   <= '0;
            delay_q      <= '0;
            bcd_q        <= '0;
            state_q      <= IDLE;
            led_go_q     <= 1'b0;
            foul_q       <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_prev_q <= start_prev_d;
            start_edge_q <= start_edge_d;
            stop_s1_q    <= stop_s1_d;
            stop_s2_q    <= stop_s2_d;
            stop_prev_q  <= stop_prev_d;
            stop_edge_q  <= stop_edge_d;
            lfsr_q       <= lfsr_d;
            tick_cnt_q   <= tick_cnt_d;
            delay_q      <= delay_d;
            bcd_q        <= bcd_d;
            state_q      <= state_d;
            led_go_q     <= led_go_d;
            foul_q       <= foul_d;
        end
    end

    logic disp_blank, disp_dash;
    assign disp_blank = (state_q == IDLE) || (state_q == WAIT);
    assign disp_dash  = (state_q == FOUL);

    seg_scan_n #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .bcd       (bcd_q),
        .blank     (disp_blank),
        .dash      (disp_dash),
        .seg       (seg),
        .digit_sel (digit_sel)
    );

    assign led_go = led_go_q;
    assign foul   = foul_q;

endmodule
